// File: rtl/mat_mult_cfg.sv
// Run-time configurable signed matrix multiplier C = A x B (optionally C += A x B)
// with ReLU and saturate/wrap post-processing, driving three async-read SRAMs.
module mat_mult_cfg #(
    parameter int MAX_M  = 16,
    parameter int MAX_K  = 64,
    parameter int MAX_N  = 32,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int AW_A   = $clog2(MAX_M * MAX_K),
    parameter int AW_B   = $clog2(MAX_K * MAX_N),
    parameter int AW_C   = $clog2(MAX_M * MAX_N)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [$clog2(MAX_M+1)-1:0]          cfg_m,
    input  logic [$clog2(MAX_K+1)-1:0]          cfg_k,
    input  logic [$clog2(MAX_N+1)-1:0]          cfg_n,
    input  logic                                cfg_acc,
    input  logic                                cfg_relu,
    input  logic                                cfg_sat,
    output logic [AW_A-1:0]                     addr_a,
    input  logic signed [DATA_W-1:0]            data_a,
    output logic [AW_B-1:0]                     addr_b,
    input  logic signed [DATA_W-1:0]            data_b,
    output logic [AW_C-1:0]                     addr_c,
    input  logic signed [OUT_W-1:0]             data_c_rd,
    output logic signed [OUT_W-1:0]             data_c,
    output logic                                we_c,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);
    localparam int MW = $clog2(MAX_M + 1);
    localparam int KW = $clog2(MAX_K + 1);
    localparam int NW = $clog2(MAX_N + 1);
    localparam logic [MW-1:0] M_LIM = MW'(MAX_M);
    localparam logic [KW-1:0] K_LIM = KW'(MAX_K);
    localparam logic [NW-1:0] N_LIM = NW'(MAX_N);

    typedef enum logic [2:0] {IDLE, CHECK, MAC, WRITE, DONE, ERR} state_t;

    state_t state, state_nx;

    logic [MW-1:0]            m_r, i_r;
    logic [KW-1:0]            k_r, k_cnt;
    logic [NW-1:0]            n_r, j_r;
    logic                     acc_en, relu_en, sat_en;
    logic [AW_A-1:0]          a_base;
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum, relu_v;
    logic                     last_k, last_j, last_i, cfg_bad;
    logic                     pos_ovf, neg_ovf;
    logic signed [OUT_W-1:0]  result;

    assign last_k  = (k_cnt == k_r - 1'b1);
    assign last_j  = (j_r == n_r - 1'b1);
    assign last_i  = (i_r == m_r - 1'b1);
    assign cfg_bad = (m_r == '0) || (m_r > M_LIM) || (k_r == '0) || (k_r > K_LIM) ||
                     (n_r == '0) || (n_r > N_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CHECK;
            CHECK:   state_nx = cfg_bad ? ERR : MAC;
            MAC:     if (last_k) state_nx = WRITE;
            WRITE:   state_nx = (last_i && last_j) ? DONE : MAC;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Addresses are kept as running registers so no multiplier sits on the SRAM address path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_r     <= '0;
            k_r     <= '0;
            n_r     <= '0;
            acc_en  <= 1'b0;
            relu_en <= 1'b0;
            sat_en  <= 1'b0;
            i_r     <= '0;
            j_r     <= '0;
            k_cnt   <= '0;
            acc     <= '0;
            a_base  <= '0;
            addr_a  <= '0;
            addr_b  <= '0;
            addr_c  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_r     <= cfg_m;
                        k_r     <= cfg_k;
                        n_r     <= cfg_n;
                        acc_en  <= cfg_acc;
                        relu_en <= cfg_relu;
                        sat_en  <= cfg_sat;
                    end
                end
                CHECK: begin
                    i_r    <= '0;
                    j_r    <= '0;
                    k_cnt  <= '0;
                    acc    <= '0;
                    a_base <= '0;
                    addr_a <= '0;
                    addr_b <= '0;
                    addr_c <= '0;
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
                    if (!last_k) begin
                        k_cnt  <= k_cnt + 1'b1;
                        addr_a <= addr_a + 1'b1;
                        addr_b <= addr_b + AW_B'(n_r);
                    end
                end
                WRITE: begin
                    acc    <= '0;
                    k_cnt  <= '0;
                    addr_c <= addr_c + 1'b1;
                    if (last_j) begin
                        j_r    <= '0;
                        i_r    <= i_r + 1'b1;
                        a_base <= a_base + AW_A'(k_r);
                        addr_a <= a_base + AW_A'(k_r);
                        addr_b <= '0;
                    end else begin
                        j_r    <= j_r + 1'b1;
                        addr_a <= a_base;
                        addr_b <= AW_B'(j_r) + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod = data_a * data_b;

    always_comb begin
        sum     = acc + (acc_en ? {{(ACC_W-OUT_W){data_c_rd[OUT_W-1]}}, data_c_rd} : '0);
        relu_v  = (relu_en && sum[ACC_W-1]) ? '0 : sum;
        pos_ovf = !relu_v[ACC_W-1] && (|relu_v[ACC_W-2:OUT_W-1]);
        neg_ovf = relu_v[ACC_W-1] && !(&relu_v[ACC_W-2:OUT_W-1]);
        if (sat_en && pos_ovf)      result = {1'b0, {(OUT_W-1){1'b1}}};
        else if (sat_en && neg_ovf) result = {1'b1, {(OUT_W-1){1'b0}}};
        else                        result = relu_v[OUT_W-1:0];
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE) || (state == ERR);
    assign err    = (state == ERR);
    assign we_c   = (state == WRITE);
    assign data_c = (state == WRITE) ? result : '0;

endmodule

// File: tb/tb_mat_mult_cfg.sv
// Directed self-checking bench for mat_mult_cfg with behavioural A/B/C SRAMs.
module tb_mat_mult_cfg;
    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               start = 1'b0;
    logic [4:0]         cfg_m = '0;
    logic [6:0]         cfg_k = '0;
    logic [5:0]         cfg_n = '0;
    logic               cfg_acc = 1'b0, cfg_relu = 1'b0, cfg_sat = 1'b0;
    logic [9:0]         addr_a;
    logic [10:0]        addr_b;
    logic [8:0]         addr_c;
    logic signed [15:0] data_a, data_b;
    logic signed [31:0] data_c_rd, data_c;
    logic               we_c, busy, done, err;

    logic signed [15:0] mem_a [1024];
    logic signed [15:0] mem_b [2048];
    logic signed [31:0] mem_c [512];

    int total = 0;
    int bad = 0;
    int wr_addr [$];

    mat_mult_cfg dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_acc(cfg_acc), .cfg_relu(cfg_relu), .cfg_sat(cfg_sat),
        .addr_a(addr_a), .data_a(data_a), .addr_b(addr_b), .data_b(data_b),
        .addr_c(addr_c), .data_c_rd(data_c_rd), .data_c(data_c), .we_c(we_c),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign data_a    = mem_a[addr_a];
    assign data_b    = mem_b[addr_b];
    assign data_c_rd = mem_c[addr_c];

    always @(posedge clk) if (we_c) mem_c[addr_c] <= data_c;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one job from IDLE; optional start poke at cycle poke_cyc to prove it is ignored.
    task automatic applyStimulus(input int m, input int k, input int n,
                                 input bit acc, input bit relu, input bit sat, input int poke_cyc,
                                 output int done_cyc, output int nwr, output bit saw_err);
        int cyc;
        done_cyc = -1;
        nwr      = 0;
        saw_err  = 1'b0;
        wr_addr.delete();
        @(negedge clk);
        cfg_m = 5'(m); cfg_k = 7'(k); cfg_n = 6'(n);
        cfg_acc = acc; cfg_relu = relu; cfg_sat = sat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 30000) begin
            start = (cyc == poke_cyc);
            if (cyc == poke_cyc) begin
                cfg_m = 5'd1; cfg_k = 7'd1; cfg_n = 6'd1; cfg_acc = 1'b1;
            end
            if (we_c) begin
                nwr++;
                wr_addr.push_back(int'(addr_c));
            end
            if (done) begin
                done_cyc = cyc;
                saw_err  = err;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic load_small();
        for (int x = 0; x < 6; x++) begin
            mem_a[x] = 16'(x + 1);
            mem_b[x] = 16'(x + 7);
        end
    endtask

    task automatic fill_c(input int v);
        for (int x = 0; x < 512; x++) mem_c[x] = 32'(v);
    endtask

    task automatic check_small(input string tag, input int off);
        checkOutput({tag, "_c00"}, mem_c[0], 58 + off);
        checkOutput({tag, "_c01"}, mem_c[1], 64 + off);
        checkOutput({tag, "_c10"}, mem_c[2], 139 + off);
        checkOutput({tag, "_c11"}, mem_c[3], 154 + off);
    endtask

    task automatic run_sat(input string tag, input int a, input int b,
                           input bit relu, input bit sat, input longint exp);
        int dc, nw;
        bit se;
        for (int x = 0; x < 4; x++) begin
            mem_a[x] = 16'(a);
            mem_b[x] = 16'(b);
        end
        fill_c(0);
        applyStimulus(1, 4, 1, 1'b0, relu, sat, -1, dc, nw, se);
        checkOutput({tag, "_done_cyc"}, dc, 7);
        checkOutput(tag, mem_c[0], exp);
    endtask

    task automatic run_err(input string tag, input int m, input int k, input int n);
        int dc, nw;
        bit se;
        applyStimulus(m, k, n, 1'b0, 1'b0, 1'b0, -1, dc, nw, se);
        checkOutput({tag, "_done_cyc"}, dc, 2);
        checkOutput({tag, "_err"}, se, 1);
        checkOutput({tag, "_writes"}, nw, 0);
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int dc, nw, cyc;
        bit se;
        longint g;
        fill_c(0);
        for (int x = 0; x < 1024; x++) mem_a[x] = '0;
        for (int x = 0; x < 2048; x++) mem_b[x] = '0;

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_we", we_c, 0);
        checkOutput("rst_data_c", data_c, 0);
        checkOutput("rst_addr", {addr_a, addr_b, addr_c}, 0);
        reset_n = 1'b1;

        // Full default-size run against an in-bench golden model.
        for (int x = 0; x < 16 * 49; x++) mem_a[x] = 16'(int'($urandom_range(46)) - 23);
        for (int x = 0; x < 49 * 32; x++) mem_b[x] = 16'(int'($urandom_range(46)) - 23);
        applyStimulus(16, 49, 32, 1'b0, 1'b0, 1'b0, -1, dc, nw, se);
        checkOutput("dflt_done_cyc", dc, 512 * 50 + 2);
        checkOutput("dflt_writes", nw, 512);
        checkOutput("dflt_err", se, 0);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 32; j++) begin
                g = 0;
                for (int k = 0; k < 49; k++) g += longint'(mem_a[i*49+k]) * longint'(mem_b[k*32+j]);
                checkOutput("dflt_elem", mem_c[i*32+j], g);
            end

        // Abort a default run at cycle 100 with reset.
        @(negedge clk);
        cfg_m = 5'd16; cfg_k = 7'd49; cfg_n = 6'd32; cfg_acc = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_we", we_c, 0);
        checkOutput("abort_done_err", {done, err}, 0);
        checkOutput("abort_data_c", data_c, 0);
        checkOutput("abort_addr", {addr_a, addr_b, addr_c}, 0);
        cyc = 0;
        for (int x = 0; x < 6; x++) begin
            @(negedge clk);
            if (x == 3) reset_n = 1'b1;
            if (we_c) cyc++;
        end
        checkOutput("abort_no_we", cyc, 0);

        // 2x3x2 directed case after the abort.
        load_small();
        fill_c(0);
        applyStimulus(2, 3, 2, 1'b0, 1'b0, 1'b0, -1, dc, nw, se);
        checkOutput("small_done_cyc", dc, 18);
        checkOutput("small_writes", nw, 4);
        for (int x = 0; x < 4; x++)
            checkOutput("small_waddr", (x < wr_addr.size()) ? wr_addr[x] : -1, x);
        check_small("small", 0);

        fill_c(100);
        applyStimulus(2, 3, 2, 1'b1, 1'b0, 1'b0, -1, dc, nw, se);
        check_small("accum", 100);

        fill_c(0);
        applyStimulus(2, 3, 2, 1'b0, 1'b0, 1'b0, 5, dc, nw, se);
        checkOutput("poke_done_cyc", dc, 18);
        checkOutput("poke_writes", nw, 4);
        check_small("poke", 0);

        run_sat("sat_pos",   -32768, -32768, 1'b0, 1'b1, 64'sd2147483647);
        run_sat("sat_neg",   -32768,  32767, 1'b0, 1'b1, -64'sd2147483648);
        run_sat("relu",      -32768,  32767, 1'b1, 1'b1, 0);
        run_sat("wrap_neg",  -32768,  32767, 1'b0, 1'b0, 131072);
        run_sat("wrap_pos",  -32768, -32768, 1'b0, 1'b0, 0);

        run_err("err_k0", 2, 0, 2);
        run_err("err_m17", 17, 3, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mat_mult_cfg.md
# mat_mult_cfg

Parametrised, run-time-configurable signed matrix multiplier computing C = A×B (optionally C = C + A×B), with ReLU and saturation post-processing. Successor to the fixed 16×49×32 multiplier. Sits beside three single-port async-read SRAMs, all row-major: A (M×K), B (K×N), C (M×N). Issues one MAC per cycle and one C write per output element.

## Interface
Parameters:
- MAX_M, 16, maximum rows of A
- MAX_K, 64, maximum inner dimension
- MAX_N, 32, maximum columns of B
- DATA_W, 16, signed A/B element width
- ACC_W, 40, signed accumulator width; must be ≥ 2·DATA_W + clog2(MAX_K)
- OUT_W, 32, signed C element width
- AW_A / AW_B / AW_C, clog2(MAX_M·MAX_K) / clog2(MAX_K·MAX_N) / clog2(MAX_M·MAX_N), SRAM address widths

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_m / cfg_k / cfg_n  in  clog2(MAX+1) each  run-time dimensions, latched on accepted start
- cfg_acc  in  1  1: C = C_old + A×B
- cfg_relu  in  1  1: clamp negative results to 0
- cfg_sat  in  1  1: saturate to OUT_W; 0: truncate (wrap)
- addr_a  out  AW_A;  data_a  in  DATA_W signed
- addr_b  out  AW_B;  data_b  in  DATA_W signed
- addr_c  out  AW_C  shared read/write address
- data_c_rd  in  OUT_W signed  old C value (async read)
- data_c  out  OUT_W signed  write data;  we_c  out  1  write strobe
- busy  out  1;  done  out  1;  err  out  1

## Operation
- Config is latched on accepted start and held for the whole run; cfg input changes mid-run are ignored.
- States:
  - IDLE: on start, go to CHECK.
  - CHECK: any dimension is 0 or above its maximum → ERR; otherwise clear i, j, k and acc, then go to MAC.
  - MAC: addr_a = i·K + k; addr_b = k·N + j; acc += data_a·data_b. When k = K−1, go to WRITE.
  - WRITE:
    - addr_c = i·N + j.
    - r = acc, or acc + sign-extended data_c_rd when cfg_acc = 1.
    - Apply ReLU, then saturate or truncate to OUT_W.
    - Drive we_c = 1 and data_c = r.
    - Clear acc and k, then advance j (then i) in row-major order.
    - After the last element, go to DONE; otherwise go to MAC.
  - DONE: done = 1 for one cycle, then IDLE.
  - ERR: err = 1 and done = 1 for one cycle, then IDLE. No SRAM writes occur.
- Arithmetic:
  - Product is 2·DATA_W signed, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W; with legal parameters it never overflows.
  - Saturation bounds are −2^(OUT_W−1) and 2^(OUT_W−1)−1.
- WRITE reads and writes the same addr_c in one cycle. The old value is read combinationally and the new value is committed at the clock edge.
- busy = 1 in every state except IDLE.
- start outside IDLE is ignored.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; all addr_* = 0, data_c = 0, we_c = 0, busy = 0, done = 0, err = 0.
- Reset asserted mid-run aborts immediately. No further we_c; writes already committed are left as-is.
- Cycle numbering: start is sampled at edge 0; cycle 1 is CHECK.
- Element e (0-based, row-major) takes K MAC cycles, then 1 WRITE cycle.
  - MAC cycles are 2 + e(K+1) … 1 + e(K+1) + K.
  - WRITE is cycle 2 + e(K+1) + K.
- done is asserted in cycle 2 + M·N·(K+1); total latency is M·N·(K+1) + 2 cycles.
- ERR path: err and done are asserted in cycle 2.
- A new start is accepted in the cycle after done.
- All outputs are registered or decoded from state only; there is no combinational path from data_* to control.
- data_c has no combinational dependence on start or cfg_* inputs.

## Test plan
- Defaults, M,K,N = 16,49,32; random A,B in [−23,23]; compare to golden model -> all 512 C match; done at cycle 512·50+2 after start; exactly 512 we_c pulses.
- M,K,N = 2,3,2; A = [1 2 3; 4 5 6]; B = [7 8; 9 10; 11 12] -> C = [58 64; 139 154]; writes to addr_c 0,1,2,3 in order.
- cfg_acc = 1; C preloaded to 100; same 2×3×2 data -> C = [158 164; 239 254].
- OUT_W = 16, K = 4; A = B = 32767:
  - cfg_sat = 1 -> C = 32767.
  - A = −32768, B = 32767, cfg_sat = 1 -> C = −32768.
  - Same data, cfg_relu = 1 -> C = 0.
  - cfg_sat = 0 -> C equals the low 16 bits of the exact sum.
- cfg_k = 0 or cfg_m = MAX_M+1 -> err and done high in cycle 2; no we_c; busy low afterwards. start pulsed while busy -> ignored, result unchanged.
- reset_n pulled low at cycle 100 of a default run -> all outputs 0 immediately; no we_c afterwards; a fresh start then completes with correct results.
